// File: rtl/gemm_pkg.sv
// Shared types for the GEMM operand fetcher: FSM states,
// buffered tile entry and SRAM word width.
package gemm_pkg;

  localparam int IN_DW     = 8;
  localparam int MESH_ROW  = 4;
  localparam int MESH_COL  = 4;
  localparam int TILE_SIZE = 4;
  localparam int SIZE_AW   = 8;

  localparam int SRAM_AB_Width =
    MESH_ROW * TILE_SIZE * IN_DW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_e;

  typedef struct packed {
    logic [SRAM_AB_Width-1:0] a;
    logic [SRAM_AB_Width-1:0] b;
    logic                     first_k;
    logic                     last_k;
    logic [SIZE_AW-1:0]       m;
    logic [SIZE_AW-1:0]       n;
  } operand_tile_t;

endpackage

// File: rtl/gemm_operand_fetcher_if.sv
// Tile stream from the operand fetcher to the mesh:
// paired A/B tiles, k-boundary flags and block coordinates.
interface gemm_operand_fetcher_if
  import gemm_pkg::*;
#(
  parameter int DW = SRAM_AB_Width,
  parameter int SW = SIZE_AW
);

  logic [DW-1:0] tile_a_o;
  logic [DW-1:0] tile_b_o;
  logic          tile_valid_o;
  logic          tile_ready_i;
  logic          tile_first_k_o;
  logic          tile_last_k_o;
  logic [SW-1:0] tile_m_o;
  logic [SW-1:0] tile_n_o;

  modport master (
    output tile_a_o, tile_b_o,
    output tile_valid_o,
    output tile_first_k_o, tile_last_k_o,
    output tile_m_o, tile_n_o,
    input  tile_ready_i
  );

  modport slave (
    input  tile_a_o, tile_b_o,
    input  tile_valid_o,
    input  tile_first_k_o, tile_last_k_o,
    input  tile_m_o, tile_n_o,
    output tile_ready_i
  );

endinterface

// File: rtl/gemm_tile_fifo.sv
// Two-entry valid/ready FIFO; the head entry is driven
// straight from storage so it holds while stalled.
module gemm_tile_fifo #(
  parameter type T = logic [7:0]
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_push,
  input  T           i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output T           o_data,
  output logic [1:0] o_count
);

  T           r_mem [2];
  logic       r_wr;
  logic       r_rd;
  logic [1:0] r_cnt;
  logic       w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign w_pop   = o_valid && i_ready;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, i_push}
                     - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/gemm_operand_fetcher.sv
// Walks the M/N/K block nest, reads SRAM A/B and streams tiles.
// Optional stall counter: define GEMM_FETCH_PERF_EN.
module gemm_operand_fetcher
  import gemm_pkg::*;
#(
  parameter int InDataWidth   = IN_DW,
  parameter int meshRow       = MESH_ROW,
  parameter int meshCol       = MESH_COL,
  parameter int tileSize      = TILE_SIZE,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = SIZE_AW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  input  logic [meshRow*tileSize*InDataWidth-1:0]
                                   sram_a_rdata_i,
  input  logic [meshCol*tileSize*InDataWidth-1:0]
                                   sram_b_rdata_i,
  gemm_operand_fetcher_if.master   tile,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              stall_cycles_o
);

  localparam int SW = SizeAddrWidth;
  localparam int AW = AddrWidth;

  fetch_state_e  r_state, w_state_nx;
  logic [SW-1:0] r_msz, r_ksz, r_nsz;
  logic [SW-1:0] r_m, r_n, r_k;
  logic [AW-1:0] r_a_base, r_b_base;
  logic [AW-1:0] r_a_addr, r_b_addr;
  logic [AW-1:0] w_a_addr, w_b_addr, w_kext;
  logic          r_inflight;
  logic          r_first, r_last;
  logic [SW-1:0] r_pm, r_pn;
  logic          w_start, w_zero, w_issue, w_pop;
  logic          w_k_last, w_n_last, w_m_last;
  logic [1:0]    w_cnt;
  logic [2:0]    w_credit;
  operand_tile_t w_push_data, w_head;

  assign w_start  = (r_state == IDLE) && start_i;
  assign w_zero   = (M_size_i == '0) ||
                    (K_size_i == '0) ||
                    (N_size_i == '0);
  assign w_k_last = (r_k == r_ksz - SW'(1));
  assign w_n_last = (r_n == r_nsz - SW'(1));
  assign w_m_last = (r_m == r_msz - SW'(1));
  assign w_kext   = AW'(r_ksz);
  assign w_a_addr = r_a_base + AW'(r_k);
  assign w_b_addr = r_b_base + AW'(r_k);

  // Credit counts the slot freed by a same-cycle pop, so a
  // ready consumer sees one tile per cycle with no bubbles.
  assign w_pop    = tile.tile_valid_o && tile.tile_ready_i;
  assign w_credit = {1'b0, w_cnt} + {2'b0, r_inflight}
                  - {2'b0, w_pop};
  assign w_issue  = (r_state == FETCH) && (w_credit < 3'd2);

  assign sram_a_addr_o = w_issue ? w_a_addr : r_a_addr;
  assign sram_b_addr_o = w_issue ? w_b_addr : r_b_addr;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:
        if (start_i) w_state_nx = w_zero ? DRAIN : FETCH;
      FETCH:
        if (w_issue && w_k_last && w_n_last && w_m_last)
          w_state_nx = DRAIN;
      DRAIN:
        if (!r_inflight && (w_cnt == {1'b0, w_pop}))
          w_state_nx = DONE;
      DONE:
        w_state_nx = IDLE;
      default:
        w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_msz      <= '0;
      r_ksz      <= '0;
      r_nsz      <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_a_base   <= '0;
      r_b_base   <= '0;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
      r_inflight <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_pm       <= '0;
      r_pn       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_start) begin
        r_msz    <= M_size_i;
        r_ksz    <= K_size_i;
        r_nsz    <= N_size_i;
        r_m      <= '0;
        r_n      <= '0;
        r_k      <= '0;
        r_a_base <= '0;
        r_b_base <= '0;
      end else if (w_issue) begin
        r_a_addr <= w_a_addr;
        r_b_addr <= w_b_addr;
        r_first  <= (r_k == '0);
        r_last   <= w_k_last;
        r_pm     <= r_m;
        r_pn     <= r_n;
        if (!w_k_last) begin
          r_k <= r_k + SW'(1);
        end else begin
          r_k <= '0;
          if (w_n_last) begin
            r_n      <= '0;
            r_b_base <= '0;
            r_m      <= r_m + SW'(1);
            r_a_base <= r_a_base + w_kext;
          end else begin
            r_n      <= r_n + SW'(1);
            r_b_base <= r_b_base + w_kext;
          end
        end
      end
    end
  end

  always_comb begin
    w_push_data         = '0;
    w_push_data.a       = sram_a_rdata_i;
    w_push_data.b       = sram_b_rdata_i;
    w_push_data.first_k = r_first;
    w_push_data.last_k  = r_last;
    w_push_data.m       = r_pm;
    w_push_data.n       = r_pn;
  end

  gemm_tile_fifo #(
    .T(operand_tile_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .o_valid (tile.tile_valid_o),
    .i_ready (tile.tile_ready_i),
    .o_data  (w_head),
    .o_count (w_cnt)
  );

  assign tile.tile_a_o       = w_head.a;
  assign tile.tile_b_o       = w_head.b;
  assign tile.tile_first_k_o = w_head.first_k;
  assign tile.tile_last_k_o  = w_head.last_k;
  assign tile.tile_m_o       = w_head.m;
  assign tile.tile_n_o       = w_head.n;

  assign busy_o = (r_state == FETCH) || (r_state == DRAIN);
  assign done_o = (r_state == DONE);

`ifdef GEMM_FETCH_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
    end else if (w_start) begin
      r_stall <= '0;
    end else if (tile.tile_valid_o && !tile.tile_ready_i
                 && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_gemm_operand_fetcher.sv
// Directed bench for gemm_operand_fetcher: table of launches
// plus hand sequences for reset and start-while-busy.
module tb_gemm_operand_fetcher;
  import gemm_pkg::*;

  localparam int DW = SRAM_AB_Width;
  localparam int SW = SIZE_AW;
  localparam int AW = 12;

  typedef struct {
    int m;
    int k;
    int n;
    int mode;
    int tiles;
    int done_cyc;
    int stalls;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] msz = '0;
  logic [SW-1:0] ksz = '0;
  logic [SW-1:0] nsz = '0;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rdata = '0;
  logic [DW-1:0] b_rdata = '0;
  logic          busy, done;
  logic [31:0]   stalls;

  int checks = 0;
  int failures = 0;

  vec_t tbl [8];
  int   a_seq [12];
  int   b_seq [12];

  gemm_operand_fetcher_if #(.DW(DW), .SW(SW)) u_if ();

  gemm_operand_fetcher u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start),
    .M_size_i       (msz),
    .K_size_i       (ksz),
    .N_size_i       (nsz),
    .sram_a_addr_o  (a_addr),
    .sram_b_addr_o  (b_addr),
    .sram_a_rdata_i (a_rdata),
    .sram_b_rdata_i (b_rdata),
    .tile           (u_if),
    .busy_o         (busy),
    .done_o         (done),
    .stall_cycles_o (stalls)
  );

  always #5 clk = ~clk;

  // SRAM word encodes its own address so tiles reveal it
  always @(posedge clk) begin
    a_rdata <= DW'(32'hA0000 | 32'(a_addr));
    b_rdata <= DW'(32'hB0000 | 32'(b_addr));
  end

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(int mode, int c);
    if (mode != 1) return 1'b1;
    if (c >= 3 && c <= 6) return 1'(c % 2);
    if (c >= 7 && c <= 16) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input vec_t v);
    int idx, done_c, first_v, em, en, ek, exp_st;
    logic [AW-1:0] a0, b0;
    idx = 0;
    done_c = -1;
    first_v = -1;
    @(negedge clk);
    a0 = a_addr;
    b0 = b_addr;
    start = 1'b1;
    msz = SW'(v.m);
    ksz = SW'(v.k);
    nsz = SW'(v.n);
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge clk);
      start = (v.mode == 2) && (c == 4);
      if (start) begin
        msz = SW'(1);
        ksz = SW'(1);
        nsz = SW'(1);
      end
      u_if.tile_ready_i = rdy(v.mode, c);
      if (c == 1) chk("busy_c1", busy, 1);
      if (u_if.tile_valid_o) begin
        if (first_v < 0) first_v = c;
        if (idx >= v.tiles) begin
          chk("extra_tile", idx, v.tiles - 1);
        end else begin
          ek = idx % v.k;
          en = (idx / v.k) % v.n;
          em = idx / (v.k * v.n);
          chk("tile_a", u_if.tile_a_o,
              DW'(32'hA0000 | ((em * v.k + ek) & 32'hFFF)));
          chk("tile_b", u_if.tile_b_o,
              DW'(32'hB0000 | ((en * v.k + ek) & 32'hFFF)));
          chk("first_k", u_if.tile_first_k_o, ek == 0);
          chk("last_k", u_if.tile_last_k_o, ek == v.k - 1);
          chk("tile_m", u_if.tile_m_o, em);
          chk("tile_n", u_if.tile_n_o, en);
          if (v.m == 2 && v.k == 3 && v.n == 2) begin
            chk("a_seq", u_if.tile_a_o[11:0], a_seq[idx]);
            chk("b_seq", u_if.tile_b_o[11:0], b_seq[idx]);
          end
        end
        if (u_if.tile_ready_i) idx++;
      end
      if (v.tiles == 0) begin
        chk("addr_a_hold", a_addr, a0);
        chk("addr_b_hold", b_addr, b0);
      end
      if (done) begin
        done_c = c;
        chk("busy_at_done", busy, 0);
      end
    end
    chk("done_cycle", done_c, v.done_cyc);
    chk("tile_count", idx, v.tiles);
    chk("first_valid", first_v, (v.tiles > 0) ? 3 : -1);
`ifdef GEMM_FETCH_PERF_EN
    exp_st = v.stalls;
`else
    exp_st = 0;
`endif
    chk("stall_cycles", stalls, exp_st);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    tbl[0] = '{1, 1, 3, 0, 3, 6, 0};
    tbl[1] = '{2, 3, 2, 0, 12, 15, 0};
    tbl[2] = '{2, 2, 2, 1, 8, 23, 12};
    tbl[3] = '{1, 0, 1, 0, 0, 2, 0};
    tbl[4] = '{0, 2, 2, 0, 0, 2, 0};
    tbl[5] = '{3, 1, 1, 2, 3, 6, 0};
    tbl[6] = '{1, 4, 1, 0, 4, 7, 0};
    tbl[7] = '{2, 2, 3, 0, 12, 15, 0};
    a_seq = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    b_seq = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    u_if.tile_ready_i = 1'b1;

    #1;
    chk("rst_valid", u_if.tile_valid_o, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stalls", stalls, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Reset while one tile sits in the FIFO and one is in flight
    @(negedge clk);
    start = 1'b1;
    msz = SW'(2);
    ksz = SW'(3);
    nsz = SW'(2);
    u_if.tile_ready_i = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", u_if.tile_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", u_if.tile_valid_o, 0);
    chk("mid_rst_tile_a", u_if.tile_a_o, 0);
    chk("mid_rst_tile_b", u_if.tile_b_o, 0);
    chk("mid_rst_first", u_if.tile_first_k_o, 0);
    chk("mid_rst_a_addr", a_addr, 0);
    chk("mid_rst_b_addr", b_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_stalls", stalls, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    u_if.tile_ready_i = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
